// File: rtl/ara_runtime_perf_monitor_if.sv
// ara_runtime_perf_monitor_if: registered read port of the runtime/event perf monitor
interface ara_runtime_perf_monitor_if #(
  parameter int unsigned AddrW = 3,
  parameter int unsigned DataW = 64
) ();
  logic             rd_req_i;
  logic [AddrW-1:0] rd_addr_i;
  logic [DataW-1:0] rd_data_o;
  logic             rd_valid_o;
  modport master (output rd_req_i, rd_addr_i, input rd_data_o, rd_valid_o);
  modport slave (input rd_req_i, rd_addr_i, output rd_data_o, rd_valid_o);
endinterface

// File: rtl/ara_runtime_perf_monitor.sv
// ara_runtime_perf_monitor: kernel runtime and event counters with snapshots taken when the cluster returns idle
module ara_runtime_perf_monitor #(
  parameter int unsigned NrGroups     = 1,
  parameter int unsigned NrEvents     = 3,
  parameter int unsigned CntWidth     = 64,
  parameter bit          SaturateCnt  = 1'b1,
  parameter int unsigned SnapCntWidth = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      sw_en_i,
  input  logic                      clear_i,
  input  logic                      acc_req_valid_i,
  input  logic [NrGroups-1:0]       ara_idle_i,
  input  logic [NrEvents-1:0]       event_i,
  ara_runtime_perf_monitor_if.slave rd,
  output logic                      cnt_active_o,
  output logic                      snap_valid_o,
  output logic [SnapCntWidth-1:0]   snap_count_o,
  output logic [NrEvents:0]         overflow_o
);
  localparam int unsigned NrCnt = NrEvents + 1;
  localparam int unsigned AddrW = $clog2(NrEvents + 2);

  typedef enum logic [1:0] {IDLE, COUNT, DRAIN} state_e;

  state_e                  r_state, w_state_d;
  logic                    w_all_idle, w_snap;
  logic [NrCnt-1:0]        w_inc;
  logic [CntWidth-1:0]     r_cnt [NrCnt];
  logic [CntWidth-1:0]     r_snap [NrCnt];
  logic [NrEvents:0]       r_overflow;
  logic                    r_pending, r_snap_valid, r_rd_valid;
  logic [SnapCntWidth-1:0] r_snap_count;
  logic [CntWidth-1:0]     r_rd_data, w_rd_mux;

  assign w_all_idle   = &ara_idle_i;
  assign cnt_active_o = r_state != IDLE;
  assign w_snap       = r_pending && w_all_idle && !acc_req_valid_i;
  // counter 0 is runtime, counters 1..NrEvents follow the event strobes
  assign w_inc        = {event_i, 1'b1} & {NrCnt{cnt_active_o}};

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      IDLE:    w_state_d = (acc_req_valid_i && sw_en_i) ? COUNT : IDLE;
      COUNT:   w_state_d = sw_en_i ? COUNT : (w_all_idle ? IDLE : DRAIN);
      DRAIN:   w_state_d = sw_en_i ? COUNT : (w_all_idle ? IDLE : DRAIN);
      default: w_state_d = IDLE;
    endcase
    if (clear_i) w_state_d = IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) r_state <= IDLE;
    else r_state <= w_state_d;

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      for (int k = 0; k < NrCnt; k++) begin
        r_cnt[k]  <= '0;
        r_snap[k] <= '0;
      end
      r_overflow   <= '0;
      r_pending    <= 1'b0;
      r_snap_valid <= 1'b0;
      r_snap_count <= '0;
    end else if (clear_i) begin
      for (int k = 0; k < NrCnt; k++) begin
        r_cnt[k]  <= '0;
        r_snap[k] <= '0;
      end
      r_overflow   <= '0;
      r_pending    <= 1'b0;
      r_snap_valid <= 1'b0;
      r_snap_count <= '0;
    end else begin
      for (int k = 0; k < NrCnt; k++) begin
        if (w_inc[k]) r_cnt[k] <= (SaturateCnt && &r_cnt[k]) ? r_cnt[k] : r_cnt[k] + 1'b1;
        if (w_inc[k] && &r_cnt[k]) r_overflow[k] <= 1'b1;
        if (w_snap) r_snap[k] <= r_cnt[k];
      end
      if (w_snap) begin
        r_pending    <= 1'b0;
        r_snap_valid <= 1'b1;
        r_snap_count <= &r_snap_count ? r_snap_count : r_snap_count + 1'b1;
      end else if (acc_req_valid_i) r_pending <= 1'b1;
    end

  // snapshots are muxed from their q values, so a read colliding with a snapshot sees the old one
  always_comb begin
    w_rd_mux = '0;
    for (int k = 0; k < NrCnt; k++)
      if (rd.rd_addr_i == AddrW'(k)) w_rd_mux = r_snap[k];
    if (rd.rd_addr_i == AddrW'(NrCnt)) w_rd_mux = r_cnt[0];
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= rd.rd_req_i;
      if (rd.rd_req_i) r_rd_data <= w_rd_mux;
    end

  assign rd.rd_data_o  = r_rd_data;
  assign rd.rd_valid_o = r_rd_valid;
  assign snap_valid_o  = r_snap_valid;
  assign snap_count_o  = r_snap_count;
  assign overflow_o    = r_overflow;
endmodule

// File: tb/tb_ara_runtime_perf_monitor.sv
// tb_ara_runtime_perf_monitor: directed checks on a 64-bit two-group monitor and two 8-bit monitors (saturate/wrap)
module tb_ara_runtime_perf_monitor;
  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       sw_en = 1'b0, clear = 1'b0, acc = 1'b0;
  logic [1:0] idle = 2'b11;
  logic [2:0] ev = 3'b000;
  logic       act0, act1, act2, sv0, sv1, sv2;
  logic [15:0] sc0, sc1, sc2;
  logic [3:0] ovf0, ovf1, ovf2;
  int n_checks = 0, n_fail = 0;

  ara_runtime_perf_monitor_if #(.AddrW(3), .DataW(64)) if0 ();
  ara_runtime_perf_monitor_if #(.AddrW(3), .DataW(8))  if1 ();
  ara_runtime_perf_monitor_if #(.AddrW(3), .DataW(8))  if2 ();

  always #5 clk_i = ~clk_i;

  ara_runtime_perf_monitor #(.NrGroups(2)) dut0 (
    .clk_i(clk_i), .rst_ni(rst_ni), .sw_en_i(sw_en), .clear_i(clear), .acc_req_valid_i(acc),
    .ara_idle_i(idle), .event_i(ev), .rd(if0.slave), .cnt_active_o(act0), .snap_valid_o(sv0),
    .snap_count_o(sc0), .overflow_o(ovf0));
  ara_runtime_perf_monitor #(.CntWidth(8), .SaturateCnt(1'b1)) dut1 (
    .clk_i(clk_i), .rst_ni(rst_ni), .sw_en_i(sw_en), .clear_i(clear), .acc_req_valid_i(acc),
    .ara_idle_i(&idle), .event_i(ev), .rd(if1.slave), .cnt_active_o(act1), .snap_valid_o(sv1),
    .snap_count_o(sc1), .overflow_o(ovf1));
  ara_runtime_perf_monitor #(.CntWidth(8), .SaturateCnt(1'b0)) dut2 (
    .clk_i(clk_i), .rst_ni(rst_ni), .sw_en_i(sw_en), .clear_i(clear), .acc_req_valid_i(acc),
    .ara_idle_i(&idle), .event_i(ev), .rd(if2.slave), .cnt_active_o(act2), .snap_valid_o(sv2),
    .snap_count_o(sc2), .overflow_o(ovf2));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic rd_drive(input logic req, input logic [2:0] a);
    if0.rd_req_i = req; if0.rd_addr_i = a;
    if1.rd_req_i = req; if1.rd_addr_i = a;
    if2.rd_req_i = req; if2.rd_addr_i = a;
  endtask

  task automatic rd(input logic [2:0] a);
    rd_drive(1'b1, a);
    step(1);
    rd_drive(1'b0, 3'd0);
    check("rd_valid", if0.rd_valid_o, 1'b1);
  endtask

  initial begin
    rd_drive(1'b0, 3'd0);
    step(2);
    check("rst_active", act0, 0);
    check("rst_snap_valid", sv0, 0);
    check("rst_snap_count", sc0, 0);
    check("rst_overflow", ovf0, 0);
    check("rst_rd_valid", if0.rd_valid_o, 0);
    check("rst_rd_data", if0.rd_data_o, 0);
    rst_ni = 1'b1;
    step(1);
    // 4-cycle kernel with events 0 and 2 firing every cycle
    sw_en = 1'b1; acc = 1'b1; idle = 2'b00; ev = 3'b101;
    step(1);
    acc = 1'b0;
    check("ev_active", act0, 1);
    step(4);
    idle = 2'b11; ev = 3'b000; sw_en = 1'b0;
    rd_drive(1'b1, 3'd0);
    step(1);
    rd_drive(1'b0, 3'd0);
    check("rd_old_valid", if0.rd_valid_o, 1);
    check("rd_old_snap", if0.rd_data_o, 0);
    check("ev_snap_count", sc0, 1);
    check("ev_snap_valid", sv0, 1);
    check("ev_idle", act0, 0);
    rd(3'd0); check("ev_rt_snap", if0.rd_data_o, 4);
    rd(3'd1); check("ev_e0_snap", if0.rd_data_o, 4);
    rd(3'd2); check("ev_e1_snap", if0.rd_data_o, 0);
    rd(3'd3); check("ev_e2_snap", if0.rd_data_o, 4);
    rd(3'd5); check("ev_addr5", if0.rd_data_o, 0);
    rd(3'd4); check("ev_live_rt", if0.rd_data_o, 5);
    step(1);
    check("rd_pulse", if0.rd_valid_o, 0);
    check("rd_hold", if0.rd_data_o, 5);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("clr_snap_count", sc0, 0);
    check("clr_snap_valid", sv0, 0);
    rd(3'd0); check("clr_rt_snap", if0.rd_data_o, 0);
    rd(3'd4); check("clr_live_rt", if0.rd_data_o, 0);
    // drain: sw_en drops after 10 active cycles while busy, idle after 30
    sw_en = 1'b1; acc = 1'b1; idle = 2'b00; ev = 3'b010;
    step(1);
    acc = 1'b0;
    step(9);
    sw_en = 1'b0;
    step(1);
    check("drain_active", act0, 1);
    step(19);
    idle = 2'b11;
    step(1);
    ev = 3'b000;
    check("drain_to_idle", act0, 0);
    rd(3'd2); check("drain_e1_snap", if0.rd_data_o, 29);
    rd(3'd0); check("drain_rt_snap", if0.rd_data_o, 29);
    step(3);
    rd(3'd4); check("drain_live_frozen", if0.rd_data_o, 30);
    // multi-group: only a fully idle cluster snapshots
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    sw_en = 1'b1; acc = 1'b1; idle = 2'b00;
    step(1);
    acc = 1'b0; idle = 2'b01;
    step(3);
    check("mg_no_snap", sc0, 0);
    idle = 2'b11;
    step(1);
    check("mg_snap", sc0, 1);
    // clear colliding with a dispatch mid-kernel
    acc = 1'b1; idle = 2'b00;
    step(1);
    acc = 1'b0;
    step(3);
    clear = 1'b1; acc = 1'b1;
    step(1);
    clear = 1'b0; acc = 1'b0;
    check("cc_active", act0, 0);
    check("cc_snap_count", sc0, 0);
    check("cc_snap_valid", sv0, 0);
    check("cc_overflow", ovf0, 0);
    sw_en = 1'b0; idle = 2'b11;
    step(2);
    check("cc_pending_cleared", sc0, 0);
    rd(3'd0); check("cc_rt_snap", if0.rd_data_o, 0);
    rd(3'd4); check("cc_live_rt", if0.rd_data_o, 0);
    // 300 active cycles on 8-bit counters
    sw_en = 1'b1; acc = 1'b1; idle = 2'b00;
    step(1);
    acc = 1'b0;
    step(299);
    sw_en = 1'b0; idle = 2'b11;
    step(1);
    check("ovf_idle", act1, 0);
    check("ovf_sat_flags", ovf1, 4'b0001);
    check("ovf_wrap_flags", ovf2, 4'b0001);
    check("ovf_wide_flags", ovf0, 4'b0000);
    rd(3'd4);
    check("ovf_wide_live", if0.rd_data_o, 300);
    check("ovf_sat_live", if1.rd_data_o, 255);
    check("ovf_wrap_live", if2.rd_data_o, 44);
    rd(3'd0);
    check("ovf_wide_snap", if0.rd_data_o, 299);
    check("ovf_sat_snap", if1.rd_data_o, 255);
    check("ovf_wrap_snap", if2.rd_data_o, 43);
    // asynchronous reset mid-count
    sw_en = 1'b1; acc = 1'b1; idle = 2'b00;
    step(1);
    acc = 1'b0;
    step(5);
    check("arst_pre_active", act0, 1);
    #2 rst_ni = 1'b0;
    #1;
    check("arst_active", act0, 0);
    check("arst_overflow", ovf1, 0);
    check("arst_snap_count", sc2, 0);
    check("arst_rd_data", if0.rd_data_o, 0);
    rst_ni = 1'b1;
    step(1);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
